// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation datapath.
// The 320-bit state is five 64-bit words, with x0 at index 0 (most significant).
package ascon_pkg;

    localparam int STATE_WIDTH = 320;

    typedef logic [63:0] type_word;
    typedef type_word [0:4] type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_fsm;

endpackage

// File: rtl/sbox.sv
// Ascon 5-bit S-box. The input column is {x0,x1,x2,x3,x4}, with x0 as the MSB.
module sbox (
    input  logic [4:0] x_i,
    output logic [4:0] y_o
);

    // Table lookup of the Ascon substitution
    always_comb begin
        case (x_i)
            5'h00: y_o = 5'h04;
            5'h01: y_o = 5'h0b;
            5'h02: y_o = 5'h1f;
            5'h03: y_o = 5'h14;
            5'h04: y_o = 5'h1a;
            5'h05: y_o = 5'h15;
            5'h06: y_o = 5'h09;
            5'h07: y_o = 5'h02;
            5'h08: y_o = 5'h1b;
            5'h09: y_o = 5'h05;
            5'h0a: y_o = 5'h08;
            5'h0b: y_o = 5'h12;
            5'h0c: y_o = 5'h1d;
            5'h0d: y_o = 5'h03;
            5'h0e: y_o = 5'h06;
            5'h0f: y_o = 5'h1c;
            5'h10: y_o = 5'h1e;
            5'h11: y_o = 5'h13;
            5'h12: y_o = 5'h07;
            5'h13: y_o = 5'h0e;
            5'h14: y_o = 5'h00;
            5'h15: y_o = 5'h0d;
            5'h16: y_o = 5'h11;
            5'h17: y_o = 5'h18;
            5'h18: y_o = 5'h10;
            5'h19: y_o = 5'h0c;
            5'h1a: y_o = 5'h01;
            5'h1b: y_o = 5'h19;
            5'h1c: y_o = 5'h16;
            5'h1d: y_o = 5'h0a;
            5'h1e: y_o = 5'h0f;
            5'h1f: y_o = 5'h17;
            default: y_o = 5'h00;
        endcase
    end

endmodule

// File: rtl/sbox_layer_seq.sv
// Sequential Ascon substitution layer: NB_SBOX columns per cycle over 64/NB_SBOX cycles,
// with valid/ready handshakes on both sides and outputs taken straight from flops.
module sbox_layer_seq
    import ascon_pkg::*;
#(
    parameter int NB_SBOX = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [STATE_WIDTH-1:0] state_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [STATE_WIDTH-1:0] state_o,
    output logic                   busy_o
);

    localparam int NB_CYCLES = 64 / NB_SBOX;
    localparam int CNT_W     = (NB_CYCLES > 1) ? $clog2(NB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_CYCLES - 1);

    generate
        if (!(NB_SBOX == 1 || NB_SBOX == 2 || NB_SBOX == 4 || NB_SBOX == 8 ||
              NB_SBOX == 16 || NB_SBOX == 32 || NB_SBOX == 64)) begin : g_bad_nb_sbox
            $fatal(1, "sbox_layer_seq: NB_SBOX must be a power of two from 1 to 64");
        end
    endgenerate

    type_fsm          fsm_q;
    type_state        data_q;
    type_state        data_d;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             valid_q;
    logic             busy_q;

    logic [5:0]       base_s;
    logic [4:0]       sbox_in_s  [NB_SBOX];
    logic [4:0]       sbox_out_s [NB_SBOX];
    logic [63:0]      mask_s;
    type_state        sub_s;

    // Chunks are power-of-two aligned, so base + i never carries out of 6 bits.
    assign base_s = 6'(32'(cnt_q) * NB_SBOX);

    generate
        for (genvar i = 0; i < NB_SBOX; i++) begin : g_sbox
            assign sbox_in_s[i] = {data_q[0][base_s + 6'(i)],
                                   data_q[1][base_s + 6'(i)],
                                   data_q[2][base_s + 6'(i)],
                                   data_q[3][base_s + 6'(i)],
                                   data_q[4][base_s + 6'(i)]};

            sbox u_sbox (
                .x_i (sbox_in_s[i]),
                .y_o (sbox_out_s[i])
            );
        end
    endgenerate

    // Scatter the S-box outputs back into the current chunk; other columns hold
    always_comb begin
        mask_s = 64'h0;
        sub_s  = '{default: 64'h0};
        data_d = data_q;
        for (int i = 0; i < NB_SBOX; i++) begin
            mask_s[base_s + 6'(i)] = 1'b1;
            for (int w = 0; w < 5; w++) begin
                sub_s[w][base_s + 6'(i)] = sbox_out_s[i][3'(4 - w)];
            end
        end
        for (int w = 0; w < 5; w++) begin
            data_d[w] = (data_q[w] & ~mask_s) | (sub_s[w] & mask_s);
        end
    end

    // Control FSM with the state register and registered handshake flags
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            data_q  <= '{default: 64'h0};
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (valid_i) begin
                        data_q  <= state_i;
                        cnt_q   <= '0;
                        fsm_q   <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        fsm_q   <= IDLE;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        fsm_q   <= DONE;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        fsm_q   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        fsm_q   <= DONE;
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = data_q;
    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Directed and randomized check of sbox_layer_seq at NB_SBOX = 8, 1, 4 and 64.
// The reference uses the bitsliced Ascon S-box equations.
module tb_sbox_layer_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   vi;
    logic [3:0]   ro;
    logic [3:0]   vo;
    logic [3:0]   ri;
    logic [3:0]   bo;
    logic [319:0] si [4];
    logic [319:0] so [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sbox_layer_seq #(.NB_SBOX(8)) u_nb8 (
        .clock_i(clk), .reset_i(rst), .valid_i(vi[0]), .ready_o(ro[0]), .state_i(si[0]),
        .valid_o(vo[0]), .ready_i(ri[0]), .state_o(so[0]), .busy_o(bo[0]));
    sbox_layer_seq #(.NB_SBOX(1)) u_nb1 (
        .clock_i(clk), .reset_i(rst), .valid_i(vi[1]), .ready_o(ro[1]), .state_i(si[1]),
        .valid_o(vo[1]), .ready_i(ri[1]), .state_o(so[1]), .busy_o(bo[1]));
    sbox_layer_seq #(.NB_SBOX(4)) u_nb4 (
        .clock_i(clk), .reset_i(rst), .valid_i(vi[2]), .ready_o(ro[2]), .state_i(si[2]),
        .valid_o(vo[2]), .ready_i(ri[2]), .state_o(so[2]), .busy_o(bo[2]));
    sbox_layer_seq #(.NB_SBOX(64)) u_nb64 (
        .clock_i(clk), .reset_i(rst), .valid_i(vi[3]), .ready_o(ro[3]), .state_i(si[3]),
        .valid_o(vo[3]), .ready_i(ri[3]), .state_o(so[3]), .busy_o(bo[3]));

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] model(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    // Offer st to instance k; lat counts edges from the accepting edge (=1) until valid_o.
    task automatic run_one(input int k, input logic [319:0] st,
                           output logic [319:0] res, output int lat);
        si[k] = st;
        vi[k] = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) vi[k] = 1'b0;
        end while (vo[k] !== 1'b1 && lat < 300);
        res = so[k];
    endtask

    task automatic rand_state(output logic [319:0] st);
        for (int i = 0; i < 10; i++) st[i*32 +: 32] = $urandom;
    endtask

    logic [319:0] res;
    logic [319:0] held;
    logic [319:0] st;
    int           lat;
    logic         stable;
    int           exp_lat [4] = '{9, 65, 17, 2};

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        rst = 1'b1;
        vi  = 4'h0;
        ri  = 4'hF;
        for (int k = 0; k < 4; k++) si[k] = 320'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", vo[0], 1'b0);
        chk("rst_busy", bo[0], 1'b0);
        chk("rst_ready", ro[0], 1'b1);
        chk("rst_state", so[0], 320'h0);
        chk("rst_valid_all", vo, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors on NB_SBOX=8
        run_one(0, 320'h0, res, lat);
        chk("zero_lat", lat, 9);
        chk("zero_res", res, {64'h0, 64'h0, ONES, 64'h0, 64'h0});
        chk("zero_ready_low", ro[0], 1'b0);
        @(posedge clk); #1;
        chk("zero_idle_ready", ro[0], 1'b1);
        chk("zero_idle_valid", vo[0], 1'b0);

        run_one(0, {5{ONES}}, res, lat);
        chk("ones_lat", lat, 9);
        chk("ones_res", res, {ONES, 64'h0, ONES, ONES, ONES});
        @(posedge clk); #1;

        run_one(0, {64'h0, 64'h0, 64'h0, 64'h0, 64'h1}, res, lat);
        chk("col0_lat", lat, 9);
        chk("col0_res", res, {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1});
        @(posedge clk); #1;

        // Backpressure: hold ready_i low for 20 cycles with valid_i pulses
        ri[0] = 1'b0;
        run_one(0, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_0F0F_0F0F,
                    64'hAAAA_5555_AAAA_5555, 64'h8000_0000_0000_0001}, res, lat);
        held = model({64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_0F0F_0F0F,
                      64'hAAAA_5555_AAAA_5555, 64'h8000_0000_0000_0001});
        chk("bp_res", res, held);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            vi[0] = i[0];
            si[0] = {10{32'hDEAD_BEEF}};
            @(posedge clk); #1;
            if (vo[0] !== 1'b1 || so[0] !== held || ro[0] !== 1'b0) stable = 1'b0;
        end
        vi[0] = 1'b0;
        chk("bp_stable", stable, 1'b1);
        ri[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", vo[0], 1'b0);
        chk("bp_release_ready", ro[0], 1'b1);
        chk("bp_release_busy", bo[0], 1'b0);

        // Asynchronous reset while cnt==3
        si[0] = {5{ONES}};
        vi[0] = 1'b1;
        @(posedge clk); #1;
        vi[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", bo[0], 1'b1);
        chk("mid_ready", ro[0], 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", vo[0], 1'b0);
        chk("arst_busy", bo[0], 1'b0);
        chk("arst_ready", ro[0], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        run_one(0, {64'h0, 64'h0, 64'h0, 64'h0, 64'h1}, res, lat);
        chk("post_rst_lat", lat, 9);
        chk("post_rst_res", res, {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1});
        @(posedge clk); #1;

        // Random sweep for NB_SBOX = 1, 4, 64
        for (int k = 1; k < 4; k++) begin
            for (int n = 0; n < 100; n++) begin
                rand_state(st);
                run_one(k, st, res, lat);
                chk($sformatf("sweep%0d_lat", k), lat, exp_lat[k]);
                chk($sformatf("sweep%0d_res", k), res, model(st));
                @(posedge clk); #1;
            end
            chk($sformatf("sweep%0d_idle", k), ro[k], 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
